// File: rtl/mem_stage_lsu.sv
// rtl/mem_stage_lsu.sv - MEM-stage load/store unit: byte-lane RAM stores, extended loads, T_V register
// Optional: define MEMSTG_ALIGN_CHECK_EN to flag and suppress misaligned half/word accesses.
module mem_stage_lsu #(
  parameter int          DEPTH   = 256,
  parameter int          TV_W    = 16,
  parameter logic [31:0] TV_ADDR = 32'h0000_FFFC
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            MemWriteM,
  input  logic            MemReadM,
  input  logic [1:0]      SizeM,
  input  logic            SignedM,
  input  logic [31:0]     ALUOutM,
  input  logic [31:0]     WriteDataM,
  output logic [31:0]     ReadDataM,
  output logic            StallM,
  output logic            MisalignM,
  output logic [TV_W-1:0] T_V
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t          state_q, state_d;
  logic [31:0]     rd_q, rd_d;
  logic [1:0]      size_q, size_d;
  logic            signed_q, signed_d;
  logic [1:0]      off_q, off_d;
  logic [TV_W-1:0] tv_q, tv_d;

  logic [31:0]     mem [DEPTH];

  logic [AW-1:0]   idx;
  logic [1:0]      off;
  logic            is_mmio, is_word, is_half, misalign;
  logic            ram_we;
  logic [3:0]      be;
  logic [31:0]     wdata;
  logic [31:0]     shifted;

  assign idx     = ALUOutM[AW+1:2];
  assign is_mmio = (ALUOutM == TV_ADDR);
  assign is_word = SizeM[1];
  assign is_half = (SizeM == 2'b01);

`ifdef MEMSTG_ALIGN_CHECK_EN
  assign misalign = (MemReadM | MemWriteM) &
                    ((is_half & ALUOutM[0]) | (is_word & (|ALUOutM[1:0])));
`else
  assign misalign = 1'b0;
`endif

  assign MisalignM = misalign;
  assign T_V       = tv_q;

  // Low address bits are forced to the access alignment so a misaligned
  // request (when not trapped) lands on the enclosing half/word.
  always_comb begin
    off = ALUOutM[1:0];
    if (is_word) begin
      off = 2'b00;
    end else if (is_half) begin
      off[0] = 1'b0;
    end
  end

  always_comb begin
    be    = 4'b0000;
    wdata = WriteDataM;
    case (SizeM)
      2'b00: begin
        be    = 4'b0001 << off;
        wdata = {4{WriteDataM[7:0]}};
      end
      2'b01: begin
        be    = off[1] ? 4'b1100 : 4'b0011;
        wdata = {2{WriteDataM[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wdata = WriteDataM;
      end
    endcase
  end

  always_comb begin
    state_d   = state_q;
    rd_d      = rd_q;
    size_d    = size_q;
    signed_d  = signed_q;
    off_d     = off_q;
    tv_d      = tv_q;
    ram_we    = 1'b0;
    StallM    = 1'b0;
    ReadDataM = 32'h0;
    shifted   = rd_q >> {off_q, 3'b000};
    case (state_q)
      IDLE: begin
        if (misalign) begin
          state_d = IDLE;
        end else if (MemWriteM) begin
          if (is_mmio) begin
            tv_d = WriteDataM[TV_W-1:0];
          end else begin
            ram_we = 1'b1;
          end
        end else if (MemReadM) begin
          if (is_mmio) begin
            ReadDataM[TV_W-1:0] = tv_q;
          end else begin
            StallM   = 1'b1;
            rd_d     = mem[idx];
            size_d   = SizeM;
            signed_d = SignedM;
            off_d    = off;
            state_d  = WAIT;
          end
        end
      end
      WAIT: begin
        case (size_q)
          2'b00:   ReadDataM = {{24{signed_q & shifted[7]}}, shifted[7:0]};
          2'b01:   ReadDataM = {{16{signed_q & shifted[15]}}, shifted[15:0]};
          default: ReadDataM = shifted;
        endcase
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rd_q     <= 32'h0;
      size_q   <= 2'b00;
      signed_q <= 1'b0;
      off_q    <= 2'b00;
      tv_q     <= '0;
    end else begin
      state_q  <= state_d;
      rd_q     <= rd_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      off_q    <= off_d;
      tv_q     <= tv_d;
    end
  end

  // RAM contents survive reset; only the write is blocked while rst is high.
  always_ff @(posedge clk) begin
    if (ram_we && !rst) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb/tb_mem_stage_lsu.sv - directed table plus randomized byte-array model check of mem_stage_lsu
module tb_mem_stage_lsu;
  localparam int          DEPTH   = 256;
  localparam int          TV_W    = 16;
  localparam logic [31:0] TV_ADDR = 32'h0000_FFFC;
`ifdef MEMSTG_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            MemWriteM, MemReadM, SignedM;
  logic [1:0]      SizeM;
  logic [31:0]     ALUOutM, WriteDataM;
  logic [31:0]     ReadDataM;
  logic            StallM, MisalignM;
  logic [TV_W-1:0] T_V;

  mem_stage_lsu #(.DEPTH(DEPTH), .TV_W(TV_W), .TV_ADDR(TV_ADDR)) dut (
    .clk(clk), .rst(rst), .MemWriteM(MemWriteM), .MemReadM(MemReadM),
    .SizeM(SizeM), .SignedM(SignedM), .ALUOutM(ALUOutM), .WriteDataM(WriteDataM),
    .ReadDataM(ReadDataM), .StallM(StallM), .MisalignM(MisalignM), .T_V(T_V)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;

  logic [7:0]      mem_b [4*DEPTH];
  logic [TV_W-1:0] tv_m;

  typedef struct {
    logic        wr;
    logic        rd;
    logic [1:0]  sz;
    logic        sg;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    int          exp_stall;
  } vec_t;

  vec_t tbl [19];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic m_mis(input logic wr, input logic rd, input logic [1:0] sz,
                                 input logic [31:0] a);
    return ALIGN && (wr || rd) && ((a % nbytes(sz)) != 0);
  endfunction

  function automatic int m_base(input logic [1:0] sz, input logic [31:0] a);
    int b;
    b = int'(a % (4 * DEPTH));
    return b - (b % nbytes(sz));
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] sz, input logic sg, input logic [31:0] a);
    int n, b;
    logic [63:0] v;
    n = nbytes(sz);
    b = m_base(sz, a);
    v = 0;
    for (int i = 0; i < n; i++) v = v | (64'(mem_b[b+i]) << (8 * i));
    if (sg && n < 4 && v[8*n-1]) v = v | ~((64'd1 << (8 * n)) - 1);
    return v[31:0];
  endfunction

  task automatic m_expect(input logic wr, input logic rd, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, output logic [31:0] erd, output int est);
    erd = 0;
    est = 0;
    if (!m_mis(wr, rd, sz, a) && !wr && rd) begin
      if (a == TV_ADDR) erd = 32'(tv_m);
      else begin
        erd = m_load(sz, sg, a);
        est = 1;
      end
    end
  endtask

  task automatic m_apply(input logic wr, input logic rd, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] wd);
    int b;
    if (wr && !m_mis(wr, rd, sz, a)) begin
      if (a == TV_ADDR) tv_m = wd[TV_W-1:0];
      else begin
        b = m_base(sz, a);
        for (int i = 0; i < nbytes(sz); i++) mem_b[b+i] = wd[8*i +: 8];
      end
    end
  endtask

  // One instruction in the MEM stage; inputs are held across any stall cycle.
  task automatic access(input logic wr, input logic rd, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input int exp_stall);
    MemWriteM = wr; MemReadM = rd; SizeM = sz; SignedM = sg; ALUOutM = a; WriteDataM = wd;
    @(negedge clk);
    chk("t_v", 32'(T_V), 32'(tv_m));
    chk("misalign", 32'(MisalignM), 32'(m_mis(wr, rd, sz, a)));
    if (exp_stall != 0) begin
      chk("stall_issue", 32'(StallM), 32'd1);
      chk("rdata_in_stall", ReadDataM, 32'h0);
      @(posedge clk); #1;
      @(negedge clk);
    end
    chk("stall_clear", 32'(StallM), 32'd0);
    chk("rdata", ReadDataM, exp_rd);
    @(posedge clk); #1;
    MemWriteM = 1'b0; MemReadM = 1'b0;
  endtask

  initial begin
    logic [31:0] erd, a, wd;
    int          est, r;
    logic        wr, rd, sg;
    logic [1:0]  sz;

    tv_m = '0;
    rst = 1'b1;
    MemWriteM = 1'b0; MemReadM = 1'b0; SizeM = 2'b10; SignedM = 1'b0;
    ALUOutM = 32'h0; WriteDataM = 32'h0;

    tbl[0]  = '{1'b1, 1'b0, 2'b10, 1'b0, 32'h20,    32'h0000_0000, 32'h0,          0};
    tbl[1]  = '{1'b1, 1'b0, 2'b10, 1'b0, 32'h10,    32'hDEAD_BEEF, 32'h0,          0};
    tbl[2]  = '{1'b0, 1'b1, 2'b10, 1'b0, 32'h10,    32'h0,         32'hDEAD_BEEF,  1};
    tbl[3]  = '{1'b0, 1'b1, 2'b00, 1'b1, 32'h13,    32'h0,         32'hFFFF_FFDE,  1};
    tbl[4]  = '{1'b0, 1'b1, 2'b00, 1'b0, 32'h13,    32'h0,         32'h0000_00DE,  1};
    tbl[5]  = '{1'b0, 1'b1, 2'b01, 1'b1, 32'h12,    32'h0,         32'hFFFF_DEAD,  1};
    tbl[6]  = '{1'b1, 1'b0, 2'b00, 1'b0, 32'h11,    32'hAAAA_AA55, 32'h0,          0};
    tbl[7]  = '{1'b0, 1'b1, 2'b10, 1'b0, 32'h10,    32'h0,         32'hDEAD_55EF,  1};
    tbl[8]  = '{1'b1, 1'b0, 2'b10, 1'b0, 32'h3FC,   32'h1234_5678, 32'h0,          0};
    tbl[9]  = '{1'b1, 1'b0, 2'b10, 1'b0, TV_ADDR,   32'h0001_ABCD, 32'h0,          0};
    tbl[10] = '{1'b0, 1'b1, 2'b10, 1'b0, TV_ADDR,   32'h0,         32'h0000_ABCD,  0};
    tbl[11] = '{1'b0, 1'b1, 2'b10, 1'b0, 32'h3FC,   32'h0,         32'h1234_5678,  1};
    tbl[12] = '{1'b0, 1'b1, 2'b01, 1'b0, 32'h412,   32'h0,         32'h0000_DEAD,  1};
    tbl[13] = '{1'b1, 1'b0, 2'b10, 1'b0, 32'h22,    32'hCAFE_F00D, 32'h0,          0};
    tbl[14] = '{1'b0, 1'b1, 2'b10, 1'b0, 32'h20,    32'h0,         ALIGN ? 32'h0 : 32'hCAFE_F00D, 1};
    tbl[15] = '{1'b1, 1'b1, 2'b10, 1'b0, 32'h40,    32'h0BAD_F00D, 32'h0,          0};
    tbl[16] = '{1'b0, 1'b1, 2'b10, 1'b0, 32'h40,    32'h0,         32'h0BAD_F00D,  1};
    tbl[17] = '{1'b1, 1'b0, 2'b01, 1'b0, 32'h42,    32'h1234_BEEF, 32'h0,          0};
    tbl[18] = '{1'b0, 1'b1, 2'b11, 1'b1, 32'h40,    32'h0,         32'hBEEF_F00D,  1};

    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset_rdata", ReadDataM, 32'h0);
    chk("reset_tv", 32'(T_V), 32'h0);
    chk("reset_stall", 32'(StallM), 32'd0);
    chk("reset_misalign", 32'(MisalignM), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    foreach (tbl[i]) begin
      access(tbl[i].wr, tbl[i].rd, tbl[i].sz, tbl[i].sg, tbl[i].addr, tbl[i].wd,
             tbl[i].exp_rd, tbl[i].exp_stall);
      m_apply(tbl[i].wr, tbl[i].rd, tbl[i].sz, tbl[i].addr, tbl[i].wd);
    end

    for (int i = 0; i < 64; i++) begin
      wd = $urandom;
      access(1'b1, 1'b0, 2'b10, 1'b0, 32'(4 * i), wd, 32'h0, 0);
      m_apply(1'b1, 1'b0, 2'b10, 32'(4 * i), wd);
    end

    for (int i = 0; i < 300; i++) begin
      r  = $urandom_range(0, 9);
      wr = (r <= 3);
      rd = (r >= 3 && r <= 8);
      sz = 2'($urandom_range(0, 3));
      sg = 1'($urandom_range(0, 1));
      wd = $urandom;
      if ($urandom_range(0, 7) == 0) a = TV_ADDR;
      else begin
        a = 32'($urandom_range(0, 255));
        if ($urandom_range(0, 3) == 0) a = a | ($urandom & 32'hFFFF_FC00);
      end
      m_expect(wr, rd, sz, sg, a, erd, est);
      access(wr, rd, sz, sg, a, wd, erd, est);
      m_apply(wr, rd, sz, a, wd);
    end

    // A store request raised while the load is in WAIT must not reach RAM.
    MemReadM = 1'b1; SizeM = 2'b10; SignedM = 1'b0; ALUOutM = 32'h30;
    @(negedge clk);
    chk("wait_wr_issue_stall", 32'(StallM), 32'd1);
    @(posedge clk); #1;
    MemWriteM = 1'b1; WriteDataM = ~m_load(2'b10, 1'b0, 32'h30);
    @(negedge clk);
    chk("wait_wr_rdata", ReadDataM, m_load(2'b10, 1'b0, 32'h30));
    @(posedge clk); #1;
    MemWriteM = 1'b0; MemReadM = 1'b0;
    access(1'b0, 1'b1, 2'b10, 1'b0, 32'h30, 32'h0, m_load(2'b10, 1'b0, 32'h30), 1);

    // Reset while a load is waiting: FSM drops back to IDLE with no data.
    MemReadM = 1'b1; SizeM = 2'b10; SignedM = 1'b0; ALUOutM = 32'h10;
    @(negedge clk);
    chk("rst_wait_issue_stall", 32'(StallM), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; MemReadM = 1'b0;
    tv_m = '0;
    @(negedge clk);
    chk("rst_wait_rdata", ReadDataM, 32'h0);
    chk("rst_wait_stall", 32'(StallM), 32'd0);
    chk("rst_wait_tv", 32'(T_V), 32'h0);
    @(posedge clk); #1;
    access(1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'h0, m_load(2'b10, 1'b0, 32'h10), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
